mips_mc_ctrl: RTL and testbench
===============================

Name: mips_mc_ctrl

Overview:
- Multi-cycle control unit that sits directly upstream of the MIPS datapath.
- Consumes the datapath's Instruction word and sequences FETCH/DECODE/EXEC/MEM/WB.
- Drives every datapath control input, plus PC/IR write enables and a req/ack handshake to data memory for wait-state support.
- Replaces the flat combinational decoder so that memory latency no longer sets the clock period.

Parameters:
- MEM_TO_MAX, 15, max cycles in MEM waiting for mem_ack before bus error (1..255)
- CNT_W, 32, width of perf counters (used only with the optional feature)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- Instruction  in  32  current instruction word from datapath
- mem_ack  in  1  data memory completes the access this cycle
- ir_we  out  1  latch instruction (FETCH only)
- pc_we  out  1  commit next PC (final state of each instruction)
- RegDst  out  1  1 = rd, 0 = rt
- RegWr  out  1  register-file write strobe
- ExtOp  out  2  00 zero-ext, 01 sign-ext, 10 imm<<16
- nPC_sel  out  2  00 PC+4, 01 branch if ALU zero
- j_sel  out  1  1 = jump target
- ALUctr  out  4  0 ADD, 1 SUB, 2 OR, 3 SLT, 4 AND
- ALUSrc  out  1  1 = imm32
- MemtoReg  out  1  1 = memory data to busW
- MemWr  out  1  memory write
- move  out  2  ALU A-source select, 00 busA, 01 busB
- mem_req  out  1  memory access request
- illegal  out  1  sticky: unsupported opcode seen
- bus_err  out  1  sticky: mem_ack timeout
- state_o  out  3  current state for debug

Behaviour:
- Reset (rst = 0, async): state = FETCH, control register cleared, every output 0, sticky flags 0, timeout counter 0.
- State encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4.
- FETCH: ir_we = 1 for one cycle, then go to DECODE.
- DECODE: register opcode[31:26] and funct[5:0] into the control register.
  - Supported: R-type (op 0) addu 0x21, subu 0x23, and 0x24, or 0x25, slt 0x2A; ori 0x0D; lui 0x0F; lw 0x23; sw 0x2B; beq 0x04; j 0x02.
  - Anything else sets illegal and executes as a NOP.
  - Always go to EXEC.
- Output validity: ALUctr/ALUSrc/ExtOp/RegDst/MemtoReg/move/nPC_sel/j_sel are driven from the control register in EXEC, MEM and WB, and are 0 in FETCH and DECODE.
- EXEC:
  - beq: nPC_sel = 01, ALUctr = SUB, pc_we = 1, then FETCH.
  - j: j_sel = 1, pc_we = 1, then FETCH.
  - NOP/illegal: pc_we = 1, then FETCH.
  - lw/sw: ALUctr = ADD, ALUSrc = 1, ExtOp = 01, then MEM.
  - All others: go to WB.
- MEM:
  - mem_req = 1; MemWr = 1 for sw, held with mem_req.
  - Stay in MEM until mem_ack = 1.
  - On ack: sw → pc_we = 1, then FETCH; lw → WB.
  - Timeout: counter increments each waiting cycle; on reaching MEM_TO_MAX, set bus_err, drop the request, pc_we = 1, go to FETCH (instruction abandoned, no register write).
  - mem_ack outside MEM is ignored.
- WB: RegWr = 1 and pc_we = 1 for exactly one cycle, then FETCH.
  - R-type: RegDst = 1.
  - ori: ExtOp = 00, ALUSrc = 1, ALUctr = OR.
  - lui: ExtOp = 10, ALUSrc = 1, ALUctr = OR.
  - lw: MemtoReg = 1.
- Instruction latency in cycles: beq/j/NOP = 3; R/ori/lui = 4; sw = 4 + wait; lw = 5 + wait.
- RegWr, MemWr and pc_we are never asserted outside their stated states.
- Reset asserted mid-instruction aborts immediately with no partial write strobes.
- Sticky flags clear only on reset.

Optional Feature:
- Macro: MIPS_MC_CTRL_PERF_EN.
- With the macro: adds outputs cyc_cnt[CNT_W-1:0] (increments every cycle out of reset) and ins_cnt[CNT_W-1:0] (increments on each pc_we). Both wrap modulo 2^CNT_W and reset to 0.
- Without the macro: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package mips_pkg holds:
  - opcode/funct constants;
  - ALUctr, ExtOp, nPC_sel and move encodings;
  - state enum;
  - control-word struct {RegDst, ExtOp, ALUctr, ALUSrc, MemtoReg, is_mem, is_wr, kind}.
- One natural sub-module: mips_decode, a combinational mapping from opcode/funct to the control word plus the illegal flag. The FSM instantiates it and registers its output in DECODE.

Test Plan:
- addu (0x00432021) from reset: states 0,1,2,4; ir_we in cycle 0; RegWr = 1 with RegDst = 1 and ALUctr = 0 in cycle 3 only; pc_we only in cycle 3.
- lw 0x8C220004 with mem_ack delayed 3 cycles: mem_req high 4 cycles, ExtOp = 01, ALUSrc = 1, MemWr = 0; then WB with MemtoReg = 1, RegWr = 1; total 8 cycles.
- sw 0xAC220008 with mem_ack never asserted, MEM_TO_MAX = 15: MemWr/mem_req high 15 cycles, then bus_err = 1, pc_we pulse, FETCH, RegWr never 1.
- beq 0x10220003 then j 0x08000010: each takes 3 cycles, with nPC_sel = 01 / j_sel = 1 respectively coincident with pc_we in EXEC.
- Opcode 0x3F: illegal = 1 after DECODE, no RegWr/MemWr, pc_we in EXEC; illegal stays 1 through the following ori.
- rst pulled low during WB of ori: all outputs 0 asynchronously; after release, FETCH with ir_we = 1 on the first cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the multi-cycle MIPS control unit:
//   - opcode / funct constants of the supported instruction subset
//   - ALUctr, ExtOp, nPC_sel and move encodings
//   - FSM state constants (FETCH=0 .. WB=4) and instruction-kind enum
//   - control-word struct latched in DECODE, plus a builder function
// -----------------------------------------------------------------------------
package mips_pkg;

    // Opcodes (Instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (Instruction[5:0])
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    // ALUctr encodings
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_OR   = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;

    // ExtOp encodings
    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_HIGH = 2'b10;

    // nPC_sel encodings
    localparam logic [1:0] NPC_SEQ  = 2'b00;
    localparam logic [1:0] NPC_BEQ  = 2'b01;

    // move (ALU A-source) encodings
    localparam logic [1:0] MOVE_BUSA = 2'b00;
    localparam logic [1:0] MOVE_BUSB = 2'b01;

    // FSM states; the numeric values are visible on state_o
    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;

    // Instruction class, selects the path through the FSM
    typedef enum logic [2:0] {
        K_NOP = 3'd0,
        K_ALU = 3'd1,
        K_LW  = 3'd2,
        K_SW  = 3'd3,
        K_BEQ = 3'd4,
        K_J   = 3'd5
    } kind_e;

    // Control word latched in DECODE
    typedef struct packed {
        logic       reg_dst;
        logic [1:0] ext_op;
        logic [3:0] alu_ctr;
        logic       alu_src;
        logic       mem_to_reg;
        logic       is_mem;
        logic       is_wr;
        kind_e      kind;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        reg_dst:    1'b0,
        ext_op:     EXT_ZERO,
        alu_ctr:    ALU_ADD,
        alu_src:    1'b0,
        mem_to_reg: 1'b0,
        is_mem:     1'b0,
        is_wr:      1'b0,
        kind:       K_NOP
    };

    // Builds a control word; is_mem / is_wr are derived from the kind so
    // they can never disagree with it.
    function automatic ctrl_t mk_ctrl(
        input logic       reg_dst,
        input logic [1:0] ext_op,
        input logic [3:0] alu_ctr,
        input logic       alu_src,
        input logic       mem_to_reg,
        input kind_e      kind
    );
        ctrl_t c;
        c.reg_dst    = reg_dst;
        c.ext_op     = ext_op;
        c.alu_ctr    = alu_ctr;
        c.alu_src    = alu_src;
        c.mem_to_reg = mem_to_reg;
        c.is_mem     = (kind == K_LW) || (kind == K_SW);
        c.is_wr      = (kind == K_ALU) || (kind == K_LW);
        c.kind       = kind;
        return c;
    endfunction

endpackage

// File: rtl/mips_decode.sv
// -----------------------------------------------------------------------------
// mips_decode
// Combinational opcode/funct -> control-word mapping.
// Ports:
//   i_op      [5:0]  Instruction[31:26]
//   i_funct   [5:0]  Instruction[5:0]
//   o_ctrl    ctrl_t control word for the instruction
//   o_illegal        1 when the opcode/funct is not supported (o_ctrl = NOP)
// -----------------------------------------------------------------------------
module mips_decode
    import mips_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    output ctrl_t      o_ctrl,
    output logic       o_illegal
);

    // Opcode / funct lookup; unsupported encodings fall back to NOP
    always_comb begin
        o_ctrl    = CTRL_NOP;
        o_illegal = 1'b0;
        case (i_op)
            OP_RTYPE: begin
                case (i_funct)
                    FN_ADDU: o_ctrl = mk_ctrl(1'b1, EXT_ZERO, ALU_ADD, 1'b0, 1'b0, K_ALU);
                    FN_SUBU: o_ctrl = mk_ctrl(1'b1, EXT_ZERO, ALU_SUB, 1'b0, 1'b0, K_ALU);
                    FN_AND:  o_ctrl = mk_ctrl(1'b1, EXT_ZERO, ALU_AND, 1'b0, 1'b0, K_ALU);
                    FN_OR:   o_ctrl = mk_ctrl(1'b1, EXT_ZERO, ALU_OR,  1'b0, 1'b0, K_ALU);
                    FN_SLT:  o_ctrl = mk_ctrl(1'b1, EXT_ZERO, ALU_SLT, 1'b0, 1'b0, K_ALU);
                    default: begin
                        o_ctrl    = CTRL_NOP;
                        o_illegal = 1'b1;
                    end
                endcase
            end
            OP_ORI:  o_ctrl = mk_ctrl(1'b0, EXT_ZERO, ALU_OR,  1'b1, 1'b0, K_ALU);
            OP_LUI:  o_ctrl = mk_ctrl(1'b0, EXT_HIGH, ALU_OR,  1'b1, 1'b0, K_ALU);
            OP_LW:   o_ctrl = mk_ctrl(1'b0, EXT_SIGN, ALU_ADD, 1'b1, 1'b1, K_LW);
            OP_SW:   o_ctrl = mk_ctrl(1'b0, EXT_SIGN, ALU_ADD, 1'b1, 1'b0, K_SW);
            OP_BEQ:  o_ctrl = mk_ctrl(1'b0, EXT_ZERO, ALU_SUB, 1'b0, 1'b0, K_BEQ);
            OP_J:    o_ctrl = mk_ctrl(1'b0, EXT_ZERO, ALU_ADD, 1'b0, 1'b0, K_J);
            default: begin
                o_ctrl    = CTRL_NOP;
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// -----------------------------------------------------------------------------
// mips_mc_ctrl
// Multi-cycle control unit for the MIPS datapath. Sequences
// FETCH -> DECODE -> EXEC -> [MEM] -> [WB] and drives every datapath control
// input, the PC/IR write enables and a req/ack handshake to data memory.
//
// Parameters:
//   MEM_TO_MAX  cycles waited in MEM for mem_ack before bus error (1..255)
//   CNT_W       perf counter width (only with MIPS_MC_CTRL_PERF_EN)
// Ports:
//   clk, rst (async, active-low)
//   Instruction[31:0], mem_ack                          inputs
//   ir_we, pc_we, RegDst, RegWr, ExtOp[1:0], nPC_sel[1:0], j_sel, ALUctr[3:0],
//   ALUSrc, MemtoReg, MemWr, move[1:0], mem_req          datapath controls
//   illegal, bus_err                                     sticky status
//   state_o[2:0]                                         debug state
//   cyc_cnt, ins_cnt [CNT_W-1:0]                         only with the macro
// Optional feature macro: MIPS_MC_CTRL_PERF_EN
//
// Outputs are decoded from registered state (plus mem_ack inside MEM) and are
// forced to 0 while rst is low, so a mid-instruction reset never leaves a
// partial write strobe on the bus.
// -----------------------------------------------------------------------------
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int MEM_TO_MAX = 15,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      Instruction,
    input  logic             mem_ack,
    output logic             ir_we,
    output logic             pc_we,
    output logic             RegDst,
    output logic             RegWr,
    output logic [1:0]       ExtOp,
    output logic [1:0]       nPC_sel,
    output logic             j_sel,
    output logic [3:0]       ALUctr,
    output logic             ALUSrc,
    output logic             MemtoReg,
    output logic             MemWr,
    output logic [1:0]       move,
    output logic             mem_req,
    output logic             illegal,
    output logic             bus_err,
    output logic [2:0]       state_o
`ifdef MIPS_MC_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ins_cnt
`endif
);

    localparam logic [7:0] TO_MAX_C = 8'(MEM_TO_MAX);

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    ctrl_t      r_ctrl;
    ctrl_t      w_dec_ctrl;
    logic       w_dec_illegal;
    logic       r_illegal;
    logic       r_bus_err;
    logic [7:0] r_to_cnt;
    logic       w_in_mem;
    logic       w_timeout;
    logic       w_fields_en;
    logic       w_pc_we;
    logic       w_unused;

    // Only opcode and funct are looked at by the controller
    assign w_unused = ^Instruction[25:6];

    mips_decode u_decode (
        .i_op      (Instruction[31:26]),
        .i_funct   (Instruction[5:0]),
        .o_ctrl    (w_dec_ctrl),
        .o_illegal (w_dec_illegal)
    );

    assign w_in_mem  = (r_state == ST_MEM);
    // Timeout wins over a late ack in the same cycle: the request is dropped
    assign w_timeout = w_in_mem && (r_to_cnt == TO_MAX_C);

    // Next-state logic
    always_comb begin
        w_next_state = ST_FETCH;
        case (r_state)
            ST_FETCH:  w_next_state = ST_DECODE;
            ST_DECODE: w_next_state = ST_EXEC;
            ST_EXEC: begin
                if (r_ctrl.is_mem) begin
                    w_next_state = ST_MEM;
                end else if (r_ctrl.is_wr) begin
                    w_next_state = ST_WB;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_MEM: begin
                if (w_timeout) begin
                    w_next_state = ST_FETCH;
                end else if (mem_ack) begin
                    w_next_state = (r_ctrl.kind == K_SW) ? ST_FETCH : ST_WB;
                end else begin
                    w_next_state = ST_MEM;
                end
            end
            ST_WB:     w_next_state = ST_FETCH;
            default:   w_next_state = ST_FETCH;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Control word is captured once in DECODE and held until the next DECODE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ctrl <= CTRL_NOP;
        end else if (r_state == ST_DECODE) begin
            r_ctrl <= w_dec_ctrl;
        end else begin
            r_ctrl <= r_ctrl;
        end
    end

    // Sticky status flags, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_illegal <= r_illegal | ((r_state == ST_DECODE) & w_dec_illegal);
            r_bus_err <= r_bus_err | w_timeout;
        end
    end

    // MEM wait counter: counts unacknowledged MEM cycles, zero elsewhere
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_to_cnt <= 8'd0;
        end else if (w_in_mem && !w_timeout && !mem_ack) begin
            r_to_cnt <= r_to_cnt + 8'd1;
        end else begin
            r_to_cnt <= 8'd0;
        end
    end

    // Output decode from state and control word, all zero while in reset
    always_comb begin
        ir_we       = 1'b0;
        w_pc_we     = 1'b0;
        RegWr       = 1'b0;
        MemWr       = 1'b0;
        mem_req     = 1'b0;
        w_fields_en = 1'b0;
        if (rst) begin
            case (r_state)
                ST_FETCH: ir_we = 1'b1;
                ST_DECODE: begin
                    w_fields_en = 1'b0;
                end
                ST_EXEC: begin
                    w_fields_en = 1'b1;
                    w_pc_we     = !r_ctrl.is_mem && !r_ctrl.is_wr;
                end
                ST_MEM: begin
                    w_fields_en = 1'b1;
                    if (w_timeout) begin
                        w_pc_we = 1'b1;
                    end else begin
                        mem_req = 1'b1;
                        MemWr   = (r_ctrl.kind == K_SW);
                        w_pc_we = mem_ack && (r_ctrl.kind == K_SW);
                    end
                end
                ST_WB: begin
                    w_fields_en = 1'b1;
                    RegWr       = r_ctrl.is_wr;
                    w_pc_we     = 1'b1;
                end
                default: begin
                    w_fields_en = 1'b0;
                end
            endcase
        end else begin
            w_fields_en = 1'b0;
        end
    end

    assign pc_we    = w_pc_we;
    assign RegDst   = w_fields_en & r_ctrl.reg_dst;
    assign ExtOp    = w_fields_en ? r_ctrl.ext_op : EXT_ZERO;
    assign ALUctr   = w_fields_en ? r_ctrl.alu_ctr : ALU_ADD;
    assign ALUSrc   = w_fields_en & r_ctrl.alu_src;
    assign MemtoReg = w_fields_en & r_ctrl.mem_to_reg;
    assign nPC_sel  = (w_fields_en && (r_ctrl.kind == K_BEQ)) ? NPC_BEQ : NPC_SEQ;
    assign j_sel    = w_fields_en && (r_ctrl.kind == K_J);
    assign move     = MOVE_BUSA;
    assign illegal  = r_illegal;
    assign bus_err  = r_bus_err;
    assign state_o  = r_state;

`ifdef MIPS_MC_CTRL_PERF_EN
    logic [CNT_W-1:0] r_cyc_cnt;
    logic [CNT_W-1:0] r_ins_cnt;

    // Free-running cycle counter and retired-instruction counter (pc_we)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cyc_cnt <= {CNT_W{1'b0}};
            r_ins_cnt <= {CNT_W{1'b0}};
        end else begin
            r_cyc_cnt <= r_cyc_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            r_ins_cnt <= r_ins_cnt + {{(CNT_W-1){1'b0}}, w_pc_we};
        end
    end

    assign cyc_cnt = r_cyc_cnt;
    assign ins_cnt = r_ins_cnt;
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_mc_ctrl
// Scoreboard bench: for every cycle the driver computes the expected output
// vector from a small reference model and pushes it; the monitor pops and
// compares it on the falling edge.
// -----------------------------------------------------------------------------
module tb_mips_mc_ctrl;

    localparam int MEM_TO = 15;
    localparam int K_NOP = 0, K_ALU = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_J = 5;

    logic        clk;
    logic        rst;
    logic [31:0] Instruction;
    logic        mem_ack;
    logic        ir_we, pc_we, RegDst, RegWr, j_sel, ALUSrc, MemtoReg, MemWr;
    logic        mem_req, illegal, bus_err;
    logic [1:0]  ExtOp, nPC_sel, move;
    logic [3:0]  ALUctr;
    logic [2:0]  state_o;
`ifdef MIPS_MC_CTRL_PERF_EN
    logic [31:0] cyc_cnt, ins_cnt;
`endif

    mips_mc_ctrl #(.MEM_TO_MAX(MEM_TO), .CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .Instruction (Instruction),
        .mem_ack     (mem_ack),
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .RegDst      (RegDst),
        .RegWr       (RegWr),
        .ExtOp       (ExtOp),
        .nPC_sel     (nPC_sel),
        .j_sel       (j_sel),
        .ALUctr      (ALUctr),
        .ALUSrc      (ALUSrc),
        .MemtoReg    (MemtoReg),
        .MemWr       (MemWr),
        .move        (move),
        .mem_req     (mem_req),
        .illegal     (illegal),
        .bus_err     (bus_err),
        .state_o     (state_o)
`ifdef MIPS_MC_CTRL_PERF_EN
        ,
        .cyc_cnt     (cyc_cnt),
        .ins_cnt     (ins_cnt)
`endif
    );

    logic [23:0] obs;
    assign obs = {ir_we, pc_we, RegDst, RegWr, ExtOp, nPC_sel, j_sel, ALUctr,
                  ALUSrc, MemtoReg, MemWr, move, mem_req, illegal, bus_err, state_o};

    int          n_cmp = 0;
    int          n_err = 0;
    logic        exp_ill = 1'b0;
    logic        exp_berr = 1'b0;
    logic [23:0] exp_q[$];
    string       tag_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // f = {RegDst, ExtOp[1:0], ALUctr[3:0], ALUSrc, MemtoReg, nPC_sel[1:0], j_sel}
    function automatic logic [11:0] mkf(input logic rd, input logic [1:0] ext, input logic [3:0] alu,
                                        input logic src, input logic m2r, input logic [1:0] npc,
                                        input logic js);
        return {rd, ext, alu, src, m2r, npc, js};
    endfunction

    function automatic logic [23:0] mkv(input logic irw, input logic pcw, input logic [11:0] f,
                                        input logic rw, input logic mw, input logic rq,
                                        input logic [2:0] st);
        return {irw, pcw, f[11], rw, f[10:9], f[2:1], f[0], f[8:5], f[4], f[3],
                mw, 2'b00, rq, exp_ill, exp_berr, st};
    endfunction

    task automatic push(input string tag, input logic [23:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare one expected vector per cycle, away from the rising edge
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            check_val(tag_q.pop_front(), {8'd0, obs}, {8'd0, exp_q.pop_front()});
        end
    end

    // Runs one instruction; called at posedge+1 of its FETCH cycle and returns
    // at posedge+1 of the following FETCH cycle.
    // ack_dly: MEM cycles before mem_ack (-1 = never). noise: mem_ack held high
    // outside MEM. rst_wb: assert reset in the middle of the WB cycle.
    task automatic run_instr(input string nm, input logic [31:0] ins, input int kind,
                             input logic [11:0] f, input int ack_dly, input bit noise,
                             input bit rst_wb);
        bit is_sw;
        bit done;
        is_sw = (kind == K_SW);
        Instruction = ins;
        mem_ack = noise;
        push({nm, "_fetch"}, mkv(1'b1, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0, 3'd0));
        next_cyc();
        push({nm, "_decode"}, mkv(1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0, 3'd1));
        next_cyc();
        Instruction = 32'hFFFF_FFFF;
        if (kind == K_NOP) exp_ill = 1'b1;
        if (kind == K_NOP || kind == K_BEQ || kind == K_J) begin
            push({nm, "_exec"}, mkv(1'b0, 1'b1, f, 1'b0, 1'b0, 1'b0, 3'd2));
            next_cyc();
            mem_ack = 1'b0;
            return;
        end
        push({nm, "_exec"}, mkv(1'b0, 1'b0, f, 1'b0, 1'b0, 1'b0, 3'd2));
        next_cyc();
        if (kind == K_LW || kind == K_SW) begin
            done = 1'b0;
            for (int n = 0; !done; n++) begin
                mem_ack = (ack_dly >= 0) && (n == ack_dly);
                if (n == MEM_TO) begin
                    push({nm, "_timeout"}, mkv(1'b0, 1'b1, f, 1'b0, 1'b0, 1'b0, 3'd3));
                    next_cyc();
                    exp_berr = 1'b1;
                    mem_ack = 1'b0;
                    return;
                end else if (mem_ack) begin
                    push({nm, "_mem_ack"}, mkv(1'b0, is_sw, f, 1'b0, is_sw, 1'b1, 3'd3));
                    next_cyc();
                    done = 1'b1;
                end else begin
                    push({nm, "_mem_wait"}, mkv(1'b0, 1'b0, f, 1'b0, is_sw, 1'b1, 3'd3));
                    next_cyc();
                end
            end
            mem_ack = 1'b0;
            if (is_sw) return;
        end
        if (rst_wb) begin
            #2;
            rst = 1'b0;
            #1;
            check_val({nm, "_rst_async"}, {8'd0, obs}, 32'd0);
            next_cyc();
            check_val({nm, "_rst_hold"}, {8'd0, obs}, 32'd0);
            next_cyc();
            exp_ill = 1'b0;
            exp_berr = 1'b0;
            rst = 1'b1;
            return;
        end
        push({nm, "_wb"}, mkv(1'b0, 1'b1, f, 1'b1, 1'b0, 1'b0, 3'd4));
        next_cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] f_zero;
        f_zero = 12'd0;
        rst = 1'b0;
        Instruction = 32'd0;
        mem_ack = 1'b1;
        #3;
        check_val("reset_outputs", {8'd0, obs}, 32'd0);
        mem_ack = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        run_instr("addu", 32'h0043_2021, K_ALU, mkf(1'b1, 2'b00, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0), 0, 1'b0, 1'b0);
        run_instr("subu", 32'h0043_2023, K_ALU, mkf(1'b1, 2'b00, 4'd1, 1'b0, 1'b0, 2'b00, 1'b0), 0, 1'b0, 1'b0);
        run_instr("and",  32'h0043_2024, K_ALU, mkf(1'b1, 2'b00, 4'd4, 1'b0, 1'b0, 2'b00, 1'b0), 0, 1'b0, 1'b0);
        run_instr("or",   32'h0043_2025, K_ALU, mkf(1'b1, 2'b00, 4'd2, 1'b0, 1'b0, 2'b00, 1'b0), 0, 1'b0, 1'b0);
        run_instr("slt",  32'h0043_202A, K_ALU, mkf(1'b1, 2'b00, 4'd3, 1'b0, 1'b0, 2'b00, 1'b0), 0, 1'b0, 1'b0);
        run_instr("lw_d3", 32'h8C22_0004, K_LW, mkf(1'b0, 2'b01, 4'd0, 1'b1, 1'b1, 2'b00, 1'b0), 3, 1'b0, 1'b0);
        run_instr("lw_d0", 32'h8C22_0004, K_LW, mkf(1'b0, 2'b01, 4'd0, 1'b1, 1'b1, 2'b00, 1'b0), 0, 1'b0, 1'b0);
        run_instr("sw_d2", 32'hAC22_0008, K_SW, mkf(1'b0, 2'b01, 4'd0, 1'b1, 1'b0, 2'b00, 1'b0), 2, 1'b0, 1'b0);
        run_instr("ori",  32'h3442_00FF, K_ALU, mkf(1'b0, 2'b00, 4'd2, 1'b1, 1'b0, 2'b00, 1'b0), 0, 1'b0, 1'b0);
        run_instr("lui",  32'h3C02_1234, K_ALU, mkf(1'b0, 2'b10, 4'd2, 1'b1, 1'b0, 2'b00, 1'b0), 0, 1'b0, 1'b0);
        run_instr("beq",  32'h1022_0003, K_BEQ, mkf(1'b0, 2'b00, 4'd1, 1'b0, 1'b0, 2'b01, 1'b0), 0, 1'b1, 1'b0);
        run_instr("j",    32'h0800_0010, K_J,   mkf(1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 2'b00, 1'b1), 0, 1'b1, 1'b0);
        run_instr("sw_to", 32'hAC22_0008, K_SW, mkf(1'b0, 2'b01, 4'd0, 1'b1, 1'b0, 2'b00, 1'b0), -1, 1'b0, 1'b0);
        run_instr("ill3f", 32'hFC00_0000, K_NOP, f_zero, 0, 1'b0, 1'b0);
        run_instr("ori2", 32'h3442_00FF, K_ALU, mkf(1'b0, 2'b00, 4'd2, 1'b1, 1'b0, 2'b00, 1'b0), 0, 1'b0, 1'b0);
        run_instr("ori_rst", 32'h3442_00FF, K_ALU, mkf(1'b0, 2'b00, 4'd2, 1'b1, 1'b0, 2'b00, 1'b0), 0, 1'b0, 1'b1);
        run_instr("addu_after_rst", 32'h0043_2021, K_ALU, mkf(1'b1, 2'b00, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0), 0, 1'b0, 1'b0);
        run_instr("ill_fn0", 32'h0000_0000, K_NOP, f_zero, 0, 1'b0, 1'b0);
        run_instr("lw_end", 32'h8C22_0004, K_LW, mkf(1'b0, 2'b01, 4'd0, 1'b1, 1'b1, 2'b00, 1'b0), 1, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        check_val("queue_drain", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
